fpu_result_buffer: RTL and testbench

Output-side buffer for the shared FPU. It captures every result the FPU emits (result, flags, tag, valid) into a small FIFO and hands results to the consumer through a valid/ready handshake. The FPU datapath cannot be stalled once an operation is issued, so the block also counts in-flight operations and raises a stall toward the issuing side whenever buffered plus in-flight results could exceed capacity.

---
 rtl/fpu_defs.sv | 17 +
 rtl/fpu_resbuf_fifo.sv | 64 ++++++
 rtl/fpu_result_buffer.sv | 119 +++++++++++
 tb/tb_fpu_result_buffer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_defs.sv
// Shared FPU definitions: operand/flag/tag widths and the result-buffer
// payload type.
package fpu_defs;

    localparam int unsigned C_OP           = 32;
    localparam int unsigned C_FLAG         = 5;
    localparam int unsigned C_TAG          = 3;
    localparam int unsigned C_RESBUF_DEPTH = 4;

    // One buffered FPU result as it travels from the FPU to the consumer.
    typedef struct packed {
        logic [C_OP-1:0]   result;
        logic [C_FLAG-1:0] flags;
        logic [C_TAG-1:0]  tag;
    } fpu_result_t;

endpackage

// File: rtl/fpu_resbuf_fifo.sv
// Generic circular FIFO with write/read pointers and an occupancy counter.
// The caller decides when to push and pop; the FIFO only reports state.
module fpu_resbuf_fifo #(
    parameter int unsigned DEPTH     = 4,
    parameter type         payload_t = logic,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             Clk_CI,
    input  logic             Rst_RBI,
    input  logic             push,
    input  logic             pop,
    input  payload_t         wdata,
    output payload_t         rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    payload_t               mem [DEPTH];
    logic     [PTR_W-1:0]   wr_ptr_q;
    logic     [PTR_W-1:0]   rd_ptr_q;
    logic     [CNT_W-1:0]   cnt_q;

    // Payload storage; written at the write pointer on every accepted push.
    // NOTE: the storage array has no reset on purpose -- valid data is tracked
    // by the pointers and counter, so clearing it would only cost a reset tree.
    always_ff @(posedge Clk_CI) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = (cnt_q == DEPTH_C);
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/fpu_result_buffer.sv
// Output-side result buffer for the shared FPU. Captures every FPU result
// into a small FIFO, hands it to the consumer over valid/ready, and stalls
// the issuing side when buffered plus in-flight results could overrun it.
// Optional feature macro: FPU_RESULT_BUF_BYPASS_EN (empty-buffer bypass with
// zero-cycle latency); without it the block has no input-to-output path.
module fpu_result_buffer
    import fpu_defs::*;
#(
    parameter int unsigned DEPTH = C_RESBUF_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              Issue_SI,
    input  logic              Valid_SI,
    input  logic [C_OP-1:0]   Result_DI,
    input  logic [C_FLAG-1:0] Flags_DI,
    input  logic [C_TAG-1:0]  Tag_DI,
    output logic              Stall_SO,
    output logic              Valid_SO,
    input  logic              Ready_SI,
    output logic [C_OP-1:0]   Result_DO,
    output logic [C_FLAG-1:0] Flags_DO,
    output logic [C_TAG-1:0]  Tag_DO,
    output logic              Overflow_SO,
    output logic [CNT_W-1:0]  Count_SO
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_W1 = (CNT_W + 1)'(DEPTH);

    fpu_result_t            in_entry;
    fpu_result_t            head_entry;
    fpu_result_t            out_entry;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic                   bypass;
    logic                   push;
    logic                   pop;
    logic                   overflow_q;
    logic [CNT_W-1:0]       infl_q;
    logic [CNT_W:0]         credit_sum;

    assign in_entry = '{result: Result_DI, flags: Flags_DI, tag: Tag_DI};

`ifdef FPU_RESULT_BUF_BYPASS_EN
    // An empty buffer forwards the incoming result straight to the consumer.
    assign bypass = fifo_empty && Valid_SI;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed result the consumer takes this cycle is never written.
    assign pop  = !fifo_empty && Ready_SI;
    assign push = Valid_SI && (!fifo_full || pop) && !(bypass && Ready_SI);

    fpu_resbuf_fifo #(
        .DEPTH     (DEPTH),
        .payload_t (fpu_result_t),
        .CNT_W     (CNT_W)
    ) i_fifo (
        .Clk_CI (Clk_CI),
        .Rst_RBI(Rst_RBI),
        .push   (push),
        .pop    (pop),
        .wdata  (in_entry),
        .rdata  (head_entry),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Sticky overflow: a result arrived with the FIFO full and nothing leaving.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            overflow_q <= 1'b0;
        end else if (Valid_SI && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    // In-flight operation count, saturating at 0 and at DEPTH.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            infl_q <= '0;
        end else if (Issue_SI && !Valid_SI) begin
            if (infl_q != DEPTH_C) begin
                infl_q <= infl_q + CNT_W'(1);
            end
        end else if (Valid_SI && !Issue_SI) begin
            if (infl_q != '0) begin
                infl_q <= infl_q - CNT_W'(1);
            end
        end
    end

    // Stall from registered state only; one extra bit keeps the sum exact.
    assign credit_sum = {1'b0, fifo_count} + {1'b0, infl_q};
    assign Stall_SO   = (credit_sum >= DEPTH_W1);

    // Consumer-side head selection: bypassed input or FIFO head.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        out_entry = head_entry;
        if (bypass) begin
            out_entry = in_entry;
        end
    end

    assign Valid_SO    = !fifo_empty || bypass;
    assign Result_DO   = out_entry.result;
    assign Flags_DO    = out_entry.flags;
    assign Tag_DO      = out_entry.tag;
    assign Overflow_SO = overflow_q;
    assign Count_SO    = fifo_count;

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Self-checking bench for fpu_result_buffer. A scoreboard queue holds the
// results the buffer must deliver, in order; a small reference model tracks
// expected occupancy, in-flight count and the sticky overflow.
module tb_fpu_result_buffer;
    import fpu_defs::*;

    localparam int DEPTH = C_RESBUF_DEPTH;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              Clk_CI = 1'b0;
    logic              Rst_RBI = 1'b0;
    logic              Issue_SI = 1'b0;
    logic              Valid_SI = 1'b0;
    logic [C_OP-1:0]   Result_DI = '0;
    logic [C_FLAG-1:0] Flags_DI = '0;
    logic [C_TAG-1:0]  Tag_DI = '0;
    logic              Stall_SO;
    logic              Valid_SO;
    logic              Ready_SI = 1'b0;
    logic [C_OP-1:0]   Result_DO;
    logic [C_FLAG-1:0] Flags_DO;
    logic [C_TAG-1:0]  Tag_DO;
    logic              Overflow_SO;
    logic [CNT_W-1:0]  Count_SO;

    int          n_checks = 0;
    int          n_fail   = 0;
    fpu_result_t sb_q[$];
    int          model_cnt  = 0;
    int          model_infl = 0;
    logic        model_ovf  = 1'b0;

    fpu_result_buffer dut (
        .Clk_CI     (Clk_CI),
        .Rst_RBI    (Rst_RBI),
        .Issue_SI   (Issue_SI),
        .Valid_SI   (Valid_SI),
        .Result_DI  (Result_DI),
        .Flags_DI   (Flags_DI),
        .Tag_DI     (Tag_DI),
        .Stall_SO   (Stall_SO),
        .Valid_SO   (Valid_SO),
        .Ready_SI   (Ready_SI),
        .Result_DO  (Result_DO),
        .Flags_DO   (Flags_DO),
        .Tag_DO     (Tag_DO),
        .Overflow_SO(Overflow_SO),
        .Count_SO   (Count_SO)
    );

    always #5 Clk_CI = ~Clk_CI;

    task automatic model_clear();
        sb_q.delete();
        model_cnt  = 0;
        model_infl = 0;
        model_ovf  = 1'b0;
    endtask

    task automatic idle_inputs();
        Issue_SI = 1'b0;
        Valid_SI = 1'b0;
        Ready_SI = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs at the falling edge,
    // advance the reference model, then move to just after the rising edge.
    task automatic step(input logic iss, input logic vin, input logic rdy,
                        input logic [C_TAG-1:0] tg, input logic [C_OP-1:0] res);
        fpu_result_t item;
        fpu_result_t head;
        logic        byp;
        logic        exp_valid;
        logic        exp_stall;
        logic        pop_m;
        logic        push_m;
        item.result = res;
        item.flags  = C_FLAG'($urandom);
        item.tag    = tg;
        Issue_SI  = iss;
        Valid_SI  = vin;
        Ready_SI  = rdy;
        Result_DI = item.result;
        Flags_DI  = item.flags;
        Tag_DI    = item.tag;
        byp = 1'b0;
`ifdef FPU_RESULT_BUF_BYPASS_EN
        byp = vin && (model_cnt == 0);
`endif
        exp_valid = (model_cnt != 0) || byp;
        exp_stall = (model_cnt + model_infl) >= DEPTH;
        head = '0;
        if (byp) head = item;
        else if (sb_q.size() > 0) head = sb_q[0];

        @(negedge Clk_CI);
        n_checks++;
        if (Valid_SO !== exp_valid) begin
            n_fail++;
            $display("FAIL valid: got %b want %b at %0t", Valid_SO, exp_valid, $time);
        end
        n_checks++;
        if (Count_SO !== CNT_W'(model_cnt)) begin
            n_fail++;
            $display("FAIL count: got %0d want %0d at %0t", Count_SO, model_cnt, $time);
        end
        n_checks++;
        if (Stall_SO !== exp_stall) begin
            n_fail++;
            $display("FAIL stall: got %b want %b at %0t", Stall_SO, exp_stall, $time);
        end
        n_checks++;
        if (Overflow_SO !== model_ovf) begin
            n_fail++;
            $display("FAIL overflow: got %b want %b at %0t", Overflow_SO, model_ovf, $time);
        end
        if (exp_valid && rdy) begin
            n_checks++;
            if ({Result_DO, Flags_DO, Tag_DO} !== head) begin
                n_fail++;
                $display("FAIL data: got res=%h fl=%h tag=%0d want res=%h fl=%h tag=%0d at %0t",
                         Result_DO, Flags_DO, Tag_DO, head.result, head.flags, head.tag, $time);
            end
        end

        pop_m  = (model_cnt != 0) && rdy;
        push_m = vin && (model_cnt < DEPTH || pop_m) && !(byp && rdy);
        if (vin && model_cnt == DEPTH && !pop_m) model_ovf = 1'b1;
        if (pop_m) void'(sb_q.pop_front());
        if (push_m) sb_q.push_back(item);
        if (push_m && !pop_m) model_cnt++;
        else if (pop_m && !push_m) model_cnt--;
        if (iss && !vin) begin
            if (model_infl < DEPTH) model_infl++;
        end else if (vin && !iss) begin
            if (model_infl > 0) model_infl--;
        end

        @(posedge Clk_CI);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        Rst_RBI = 1'b0;
        #12;
        n_checks++;
        if ({Valid_SO, Stall_SO, Overflow_SO, Count_SO} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b s=%b o=%b c=%0d want all 0",
                     Valid_SO, Stall_SO, Overflow_SO, Count_SO);
        end
        model_clear();
        @(negedge Clk_CI);
        Rst_RBI = 1'b1;
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic test_single();
        step(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 3'd3, 32'h3F800000);
`ifndef FPU_RESULT_BUF_BYPASS_EN
        idle_inputs();
        #1;
        n_checks++;
        if (Valid_SO !== 1'b1 || Result_DO !== 32'h3F800000 || Tag_DO !== 3'd3) begin
            n_fail++;
            $display("FAIL single_latency: got v=%b res=%h tag=%0d want v=1 res=3f800000 tag=3",
                     Valid_SO, Result_DO, Tag_DO);
        end
`endif
        step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        idle_inputs();
        #1;
        n_checks++;
        if (Count_SO !== '0 || Valid_SO !== 1'b0) begin
            n_fail++;
            $display("FAIL single_empty: got c=%0d v=%b want c=0 v=0", Count_SO, Valid_SO);
        end
    endtask

    task automatic test_credit_stall();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
        idle_inputs();
        #1;
        n_checks++;
        if (Stall_SO !== 1'b1 || Count_SO !== '0) begin
            n_fail++;
            $display("FAIL credit_stall: got s=%b c=%0d want s=1 c=0", Stall_SO, Count_SO);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, 1'b0, C_TAG'(i), $urandom);
        idle_inputs();
        #1;
        n_checks++;
        if (Count_SO !== CNT_W'(DEPTH) || Stall_SO !== 1'b1) begin
            n_fail++;
            $display("FAIL fill: got c=%0d s=%b want c=%0d s=1", Count_SO, Stall_SO, DEPTH);
        end
        step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        idle_inputs();
        #1;
        n_checks++;
        if (Stall_SO !== 1'b0 || Tag_DO !== 3'd1) begin
            n_fail++;
            $display("FAIL drain_first: got s=%b tag=%0d want s=0 tag=1", Stall_SO, Tag_DO);
        end
        for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, 1'b0, C_TAG'(i), $urandom);
        step(1'b0, 1'b1, 1'b1, 3'd5, 32'hCAFE0005);
        idle_inputs();
        #1;
        n_checks++;
        if (Count_SO !== CNT_W'(DEPTH) || Overflow_SO !== 1'b0) begin
            n_fail++;
            $display("FAIL full_push_pop: got c=%0d o=%b want c=%0d o=0",
                     Count_SO, Overflow_SO, DEPTH);
        end
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, 1'b0, C_TAG'(i), $urandom);
        step(1'b0, 1'b1, 1'b0, 3'd7, 32'hDEAD0007);
        idle_inputs();
        #1;
        n_checks++;
        if (Overflow_SO !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got %b want 1", Overflow_SO);
        end
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        idle_inputs();
        #1;
        n_checks++;
        if (Overflow_SO !== 1'b1 || Valid_SO !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_sticky: got o=%b v=%b want o=1 v=0", Overflow_SO, Valid_SO);
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b0, 1'b1, 1'b0, 3'd1, $urandom);
        step(1'b0, 1'b1, 1'b0, 3'd2, $urandom);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
        idle_inputs();
        #2;
        Rst_RBI = 1'b0;
        #1;
        n_checks++;
        if ({Valid_SO, Stall_SO, Overflow_SO, Count_SO} !== '0) begin
            n_fail++;
            $display("FAIL reset_midstream: got v=%b s=%b o=%b c=%0d want all 0",
                     Valid_SO, Stall_SO, Overflow_SO, Count_SO);
        end
        model_clear();
        @(negedge Clk_CI);
        Rst_RBI = 1'b1;
        @(posedge Clk_CI);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic iss;
        logic vin;
        logic rdy;
        for (int i = 0; i < 8; i++)
            step(1'b1, (i > 0), 1'b1, C_TAG'(i), $urandom);
        for (int i = 0; i < 60; i++) begin
            iss = ((model_cnt + model_infl) < DEPTH) && ($urandom_range(0, 3) != 0);
            vin = (model_infl > 0) && ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            step(iss, vin, rdy, C_TAG'($urandom), $urandom);
        end
        while (model_infl > 0) step(1'b0, 1'b1, 1'b1, C_TAG'($urandom), $urandom);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drained: got %0d pending want 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_credit_stall();
        test_fill_drain();
        test_full_push_pop();
        test_overflow();
        test_reset_midstream();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
